// File: rtl/conv_encoder_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional encoder subsystem.
package conv_encoder_pkg;

  localparam int K      = 3;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_ENC,
    S_OUT
  } state_t;

  // u = {current bit, s[1], s[0]}; returns {upper, lower} code bits
  function automatic logic [1:0] code_pair(input logic [K-1:0] u,
                                           input logic [K-1:0] g0,
                                           input logic [K-1:0] g1);
    return {^(u & g0), ^(u & g1)};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and drop-on-full writes.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // NOTE: storage is deliberately left without reset; only pointers define
  // validity, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/conv_encoder_top.sv
// Byte-oriented rate-1/2, K=3 convolutional encoder: FIFO in, 16-bit coded word out.
module conv_encoder_top
  import conv_encoder_pkg::*;
#(
  parameter int           FIFO_DEPTH = 16,
  parameter logic [K-1:0] G0         = G0_DEFAULT,
  parameter logic [K-1:0] G1         = G1_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dvalid_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i
);

  state_t              state;
  state_t              next_state;
  logic                rd_en;
  logic [BYTE_W-1:0]   rd_data;
  logic                full;
  logic                empty;
  logic                rst_n;
  logic [BYTE_W-1:0]   sh;
  logic [2:0]          cnt;
  logic [K-2:0]        s;
  logic [WORD_W-3:0]   word;
  logic [WORD_W-1:0]   next_word;
  logic                flush_pending;

  assign rst_n  = ~rst;
  assign busy_o = full;

  sync_fifo #(
    .DATA_WIDTH (BYTE_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (dvalid_i),
    .wr_data (data_i),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          rd_en      = 1'b1;
          next_state = S_READ;
        end
      end
      S_READ: next_state = S_ENC;
      S_ENC:  if (cnt == 3'd7) next_state = S_OUT;
      S_OUT: begin
        if (ready_i) begin
          if (!empty) begin
            rd_en      = 1'b1;
            next_state = S_READ;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Upper bits of the 16-bit word shift out naturally after 8 pairs
  assign next_word = {word, code_pair({sh[BYTE_W-1], s}, G0, G1)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh            <= '0;
      cnt           <= '0;
      s             <= '0;
      word          <= '0;
      data_o        <= '0;
      valid_o       <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        S_READ: begin
          sh  <= rd_data;
          cnt <= '0;
          if (flush_pending || flush_i) s <= '0;
        end
        S_ENC: begin
          sh   <= {sh[BYTE_W-2:0], 1'b0};
          s    <= {sh[BYTE_W-1], s[1]};
          word <= next_word[WORD_W-3:0];
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            data_o  <= next_word;
            valid_o <= 1'b1;
          end
        end
        S_OUT:   if (ready_i) valid_o <= 1'b0;
        default: ;
      endcase

      // A flush seen outside S_READ waits for the next byte to be loaded
      if (state == S_READ) flush_pending <= 1'b0;
      else if (flush_i)    flush_pending <= 1'b1;
    end
  end

endmodule

// File: doc/conv_encoder_top.md
# conv_encoder_top

Rate-1/2, constraint-length-3 convolutional encoder subsystem; the transmit-side counterpart of the Viterbi decoder subsystem. It accepts 8-bit data bytes into an input FIFO and encodes each byte MSB-first through a 2-bit encoder state register. Each byte produces one 16-bit coded word, in exactly the layout the decoder's 16-bit input expects. The encoder state carries across bytes, so bytes form one continuous code stream, except that a flush request zeroes the state.

## Interface
- FIFO_DEPTH, 16, input FIFO depth in bytes (power of two)
- G0, 3'b111, generator polynomial for the upper output bit of each pair
- G1, 3'b101, generator polynomial for the lower output bit of each pair
- clk  input  1  single system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- dvalid_i  input  1  write strobe; data_i is pushed into the FIFO in this cycle
- data_i  input  8  data byte to encode
- flush_i  input  1  one-cycle pulse; zeroes the encoder state before the next byte
- busy_o  output  1  FIFO full, combinational from FIFO status
- data_o  output  16  coded word; pair for byte bit 7 in [15:14], bit 0 in [1:0]
- valid_o  output  1  data_o valid, held until accepted
- ready_i  input  1  sink accepts data_o when valid_o && ready_i

## Operation
- Reset values: data_o=0, valid_o=0, busy_o=0 (FIFO empty), encoder state s[1:0]=0, flush_pending=0, FSM=S_IDLE.
- FIFO write: a write occurs when dvalid_i && !full. A write while full is dropped; the FIFO contents are not overwritten.
- FIFO read is registered: rd_data is valid in the cycle after rd_en.
- FSM states and transitions:
  - S_IDLE: when !empty, assert rd_en and go to S_READ.
  - S_READ: load rd_data into shift register sh[7:0]; clear bit counter; if flush_pending or flush_i, set s<=0 and clear flush_pending; go to S_ENC.
  - S_ENC: one bit per cycle for exactly 8 cycles. Bit b=sh[7], u={b,s[1],s[0]}, g0=^(u&G0), g1=^(u&G1). Then word<={word[13:0],g0,g1}, s<={b,s[1]}, sh<=sh<<1. On the 8th cycle, load data_o<=final word and valid_o<=1, and go to S_OUT.
  - S_OUT: hold data_o and valid_o stable. On ready_i, clear valid_o. Then: if !empty, assert rd_en and go to S_READ; otherwise go to S_IDLE.
- flush_i outside S_READ sets flush_pending, which holds until the next S_READ. Multiple pulses collapse into one flush. A flush never alters a byte already in S_ENC.
- Simultaneous FIFO write and read in the same cycle is legal; the FIFO count is unchanged.
- Asserting rst in any state aborts immediately. The partial word is discarded, the FIFO empties, and s=0.

## Timing
- Latency: dvalid_i in cycle 0 with FIFO empty and FSM idle gives rd_en in cycle 1, S_READ in cycle 2, S_ENC in cycles 3–10, and valid_o=1 in cycle 11.
- Throughput with ready_i tied high and FIFO non-empty: one word per 10 cycles (S_READ, 8×S_ENC, S_OUT).
- valid_o never drops without ready_i. data_o changes only on the load into S_OUT.
- busy_o rises in the cycle after the write that fills the FIFO.

## Structure
- Shared package: FSM state encoding, K=3, the default generator constants, and the coded-word width of 16.
- Sub-module: reuse the existing sync_fifo (DATA_WIDTH=8, FIFO_DEPTH) with rst_n driven by ~rst.
- The encoder datapath and FSM live in the top module. No further hierarchy.

## Test plan
- Known words: after reset, write 0x80 -> data_o=0xEC00; write 0x00 -> 0x0000; write 0xFF -> 0xDAAA; check valid_o asserts at cycle 11.
- State continuity: write 0xFF then 0x00 with no flush -> 0xDAAA then 0x7000. Repeat with a flush_i pulse between the bytes -> 0xDAAA then 0x0000.
- Backpressure and full: hold ready_i=0 and write 18 bytes back-to-back. busy_o must assert, the 18th byte must be dropped, and data_o must stay stable. Release ready_i -> exactly 17 words out, in order.
- Handshake: toggle ready_i randomly over 50 bytes -> no word lost or duplicated, and valid_o never drops before acceptance. Check against a reference encoder model.
- Reset mid-operation: assert rst during S_ENC -> valid_o=0 and busy_o=0 immediately. After release, write 0x80 -> 0xEC00.
- Flush timing: flush_i in the same cycle as S_READ applies to that byte. flush_i during S_ENC of 0xFF is deferred, so 0xFF -> 0xDAAA and the next 0x00 -> 0x0000.
